mc_traffic_checker: RTL

Synthesizable, parametrised traffic generator and in-order response checker for `memory_controller`. It drives the controller's request port with a programmable write/read sweep and checks every returned read word against a regenerated pattern. It counts errors, cycles and timeouts so a full regression runs on the emulator with no testbench-side logic. It sits between a run-control register block and the controller's front-end request interface.

---
 rtl/mc_tg_pkg.sv | 28 ++
 rtl/mc_tg_pattern.sv | 49 ++++
 rtl/mc_traffic_checker.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mc_tg_pkg.sv
// Shared types and constants for the memory-controller traffic checker.
// Build option MC_TRAFFIC_LFSR_EN selects LFSR data patterns.
package mc_tg_pkg;

  typedef enum logic [1:0] {
    TG_IDLE,
    TG_ISSUE,
    TG_DRAIN,
    TG_DONE
  } tg_state_e;

  localparam int TG_MODE_SEQ = 0;
  localparam int TG_MODE_ILV = 1;

  localparam int TG_ERR_W = 16;
  localparam int TG_CYC_W = 32;

  // Right-shifting Galois feedback masks (maximal length).
  function automatic logic [63:0] tg_lfsr_taps(input int w);
    case (w)
      8:       return 64'h0000_0000_0000_00B8;
      32:      return 64'h0000_0000_8020_0003;
      64:      return 64'hD800_0000_0000_0000;
      default: return 64'h0000_0000_0000_B400;
    endcase
  endfunction

endpackage

// File: rtl/mc_tg_pattern.sv
// Data pattern source; counter by default, Galois LFSR when
// MC_TRAFFIC_LFSR_EN is defined.
module mc_tg_pattern
  import mc_tg_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] value
);

`ifdef MC_TRAFFIC_LFSR_EN
  localparam logic [DATA_WIDTH-1:0] SEED = '1;
  localparam logic [63:0] TAPS = tg_lfsr_taps(DATA_WIDTH);

  function automatic logic [DATA_WIDTH-1:0] nxt(
    input logic [DATA_WIDTH-1:0] s
  );
    nxt = s >> 1;
    if (s[0]) nxt = nxt ^ TAPS[DATA_WIDTH-1:0];
  endfunction
`else
  localparam logic [DATA_WIDTH-1:0] SEED = '0;

  function automatic logic [DATA_WIDTH-1:0] nxt(
    input logic [DATA_WIDTH-1:0] s
  );
    nxt = s + 1'b1;
  endfunction
`endif

  logic [DATA_WIDTH-1:0] value_q, value_d;

  // A clear shows the seed immediately so it can be consumed that cycle.
  always_comb begin
    value_d = value_q;
    if (rst) value_d = advance ? nxt(SEED) : SEED;
    else if (advance) value_d = nxt(value_q);
  end

  always_ff @(posedge clk) begin
    value_q <= value_d;
  end

  assign value = rst ? SEED : value_q;

endmodule

// File: rtl/mc_traffic_checker.sv
// Write/read sweep generator and in-order read checker for memory_controller.
// Define MC_TRAFFIC_LFSR_EN for LFSR data instead of address-index data.
module mc_traffic_checker
  import mc_tg_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 30,
  parameter int NUM_REQ      = 1024,
  parameter int BASE_ADDR    = 0,
  parameter int ADDR_STRIDE  = 1,
  parameter int IDLE_TIMEOUT = 200,
  parameter int MODE         = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  out_busy,
  output logic                  in_valid,
  output logic                  in_request_type,
  output logic [ADDR_WIDTH-1:0] in_request_address,
  output logic [DATA_WIDTH-1:0] in_request_data,
  input  logic                  write_done,
  input  logic                  read_done,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [TG_ERR_W-1:0]   err_count,
  output logic [TG_CYC_W-1:0]   cycle_count
);

  localparam int TOT = 2 * NUM_REQ;
  localparam int IW  = $clog2(TOT + 1);
  localparam int OW  = IW + 1;
  localparam int TW  = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IW-1:0] NREQ = IW'(NUM_REQ);
  localparam logic [IW-1:0] LAST = IW'(TOT - 1);

  tg_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, nidx;
  logic [OW-1:0] outs_q, outs_d, nd, spur;
  logic [TW-1:0] idle_q, idle_d;
  logic valid_q, valid_d, type_q, type_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, na;
  logic [DATA_WIDTH-1:0] data_q, data_d, wpat, rpat;
  logic busy_q, busy_d, done_q, done_d;
  logic pass_q, pass_d, tmo_q, tmo_d;
  logic [TG_ERR_W-1:0] err_q, err_d, err_sat;
  logic [TG_ERR_W:0] err_sum;
  logic [TG_CYC_W-1:0] cyc_q, cyc_d;
  logic acc, run, go, last, mism, nw, wadv, radv, fin;

  function automatic void req_of(
    input  logic [IW-1:0]         j,
    output logic                  w,
    output logic [ADDR_WIDTH-1:0] a
  );
    logic [IW-1:0] k;
    if (MODE == TG_MODE_ILV) begin
      w = ~j[0];
      k = j >> 1;
    end else begin
      w = (j < NREQ);
      k = w ? j : j - NREQ;
    end
    a = ADDR_WIDTH'(BASE_ADDR)
      + ADDR_WIDTH'(k) * ADDR_WIDTH'(ADDR_STRIDE);
  endfunction

  assign acc  = valid_q & ~out_busy;
  assign run  = (state_q == TG_ISSUE) | (state_q == TG_DRAIN);
  assign go   = start & ((state_q == TG_IDLE) | (state_q == TG_DONE));
  assign last = (idx_q == LAST);
  assign nidx = go ? '0 : idx_q + 1'b1;

  // Dones beyond what is outstanding are spurious and only count as errors.
  assign nd   = OW'(write_done) + OW'(read_done);
  assign spur = (nd > outs_q) ? nd - outs_q : '0;
  assign mism = read_done & (outs_q != '0) & (data_out != rpat);

  assign err_sum = {1'b0, err_q} + (TG_ERR_W + 1)'(spur)
                 + (TG_ERR_W + 1)'(mism);
  assign err_sat = err_sum[TG_ERR_W] ? '1 : err_sum[TG_ERR_W-1:0];

  mc_tg_pattern #(.DATA_WIDTH(DATA_WIDTH)) u_wpat (
    .clk     (clk),
    .rst     (~rst_n | go),
    .advance (wadv & rst_n),
    .value   (wpat)
  );

  mc_tg_pattern #(.DATA_WIDTH(DATA_WIDTH)) u_rpat (
    .clk     (clk),
    .rst     (~rst_n | go),
    .advance (radv & rst_n),
    .value   (rpat)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    outs_d  = outs_q;
    idle_d  = idle_q;
    valid_d = valid_q;
    type_d  = type_q;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    cyc_d   = cyc_q;
    wadv    = 1'b0;
    radv    = 1'b0;
    fin     = 1'b0;
    req_of(nidx, nw, na);
    if (run) begin
      outs_d = outs_q + OW'(acc) - (nd - spur);
      err_d  = err_sat;
      radv   = read_done & (outs_q != '0);
      cyc_d  = (&cyc_q) ? cyc_q : cyc_q + 1'b1;
      if (acc | write_done | read_done) idle_d = '0;
      else if (outs_q != '0) idle_d = idle_q + 1'b1;
      else idle_d = '0;
      if (acc) begin
        if (last) begin
          valid_d = 1'b0;
          state_d = TG_DRAIN;
        end else begin
          idx_d  = nidx;
          type_d = nw;
          addr_d = na;
          data_d = nw ? wpat : '0;
          wadv   = nw;
        end
      end
      if ((state_q == TG_DRAIN) && (outs_d == '0)) fin = 1'b1;
      if (idle_d == TW'(IDLE_TIMEOUT)) begin
        fin   = 1'b1;
        tmo_d = 1'b1;
      end
      if (fin) begin
        state_d = TG_DONE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_d == '0) & ~tmo_d;
      end
    end else if (go) begin
      state_d = TG_ISSUE;
      idx_d   = '0;
      outs_d  = '0;
      idle_d  = '0;
      err_d   = '0;
      cyc_d   = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      tmo_d   = 1'b0;
      valid_d = 1'b1;
      type_d  = nw;
      addr_d  = na;
      data_d  = nw ? wpat : '0;
      wadv    = nw;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= TG_IDLE;
      idx_q   <= '0;
      outs_q  <= '0;
      idle_q  <= '0;
      valid_q <= 1'b0;
      type_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tmo_q   <= 1'b0;
      err_q   <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      outs_q  <= outs_d;
      idle_q  <= idle_d;
      valid_q <= valid_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
    end
  end

  assign in_valid           = valid_q;
  assign in_request_type    = type_q;
  assign in_request_address = addr_q;
  assign in_request_data    = data_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign pass               = pass_q;
  assign timeout            = tmo_q;
  assign err_count          = err_q;
  assign cycle_count        = cyc_q;

endmodule
